// File: rtl/uart_freq_tx.sv
// uart_freq_tx
// Sends a captured 32-bit unsigned value over a UART line as an ASCII
// decimal frame: NUM_DIGITS digits (MSD first), then CR, then LF, 8N1.
// Binary-to-BCD is done sequentially (shift-add-3, one bit per clock).
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   value    unsigned binary value, captured on the accepted send edge
//   send     request strobe; only honoured in IDLE
//   busy     high while a frame is in progress
//   done     one-cycle pulse on the cycle the final stop bit ends
//   uart_tx  serial line, idle high, registered
//
// Optional build macro:
//   UART_TX_ZERO_SUPPRESS_EN  skip leading zero digits (the least significant
//                             digit is always sent; overflow still sends
//                             NUM_DIGITS '9' characters).
module uart_freq_tx #(
  parameter int DELAY_FRAMES = 534,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS + 2);
  localparam int CNT_W = $clog2(DELAY_FRAMES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LF   = IDX_W'(NUM_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_bin;
  logic [BCD_W-1:0] r_bcd, w_bcd_adj;
  logic             r_ovf;
  logic [4:0]       r_conv_cnt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [IDX_W-1:0] r_char_idx, w_first_idx;
  logic [6:0]       r_shift;
  logic [7:0]       w_char;
  logic [3:0]       w_digit;
  logic             r_tx, r_done;
  logic             w_accept, w_bit_end;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // A send that lands on the done cycle is deliberately dropped.
  assign w_accept  = send && !r_done;
  assign w_bit_end = (r_clk_cnt == BIT_LAST);
  assign w_bcd_adj = add3(r_bcd);

  // Character for the current index; digit index 0 is the top nibble.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_char_idx == IDX_W'(i)) w_digit = r_bcd[4*(NUM_DIGITS-1-i) +: 4];
    if (r_ovf) w_digit = 4'd9;
    if (r_char_idx == IDX_CR)      w_char = 8'h0D;
    else if (r_char_idx == IDX_LF) w_char = 8'h0A;
    else                           w_char = {4'h3, w_digit};
  end

  // Index of the first character to send.
  always_comb begin
    w_first_idx = '0;
`ifdef UART_TX_ZERO_SUPPRESS_EN
    if (!r_ovf) begin
      w_first_idx = IDX_W'(NUM_DIGITS - 1);
      // Descending scan: last hit is the most significant nonzero digit.
      for (int i = NUM_DIGITS - 1; i >= 0; i--)
        if (r_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) w_first_idx = IDX_W'(i);
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_CONVERT;
      S_CONVERT: if (r_conv_cnt == 5'd31) w_next = S_LOAD;
      S_LOAD:    w_next = S_START;
      S_START:   if (w_bit_end) w_next = S_DATA;
      S_DATA:    if (w_bit_end && r_bit_cnt == 3'd7) w_next = S_STOP;
      S_STOP:    if (w_bit_end) w_next = (r_char_idx == IDX_LF) ? S_IDLE : S_START;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath and registered line/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_conv_cnt <= '0;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_char_idx <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_conv_cnt <= '0;
            r_char_idx <= '0;
          end
        end
        S_CONVERT: begin
          // Anything shifted out of the top nibble means value >= 10^NUM_DIGITS.
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_ovf          <= r_ovf | w_bcd_adj[BCD_W-1];
          r_conv_cnt     <= r_conv_cnt + 5'd1;
        end
        S_LOAD: begin
          r_tx       <= 1'b0;
          r_clk_cnt  <= '0;
          r_char_idx <= w_first_idx;
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= w_char[0];
            r_shift   <= w_char[7:1];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_char_idx == IDX_LF) begin
              r_done <= 1'b1;
            end else begin
              // Next start bit follows with no gap.
              r_char_idx <= r_char_idx + 1'b1;
              r_tx       <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = r_done;
    uart_tx = r_tx;
  end

endmodule

// File: tb/tb_uart_freq_tx.sv
`timescale 1ns/1ps
module tb_uart_freq_tx;
  localparam int DF = 8;
  localparam int ND = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [31:0] value = '0;
  logic        busy, done, uart_tx;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  byte unsigned rx_q[$];
  byte unsigned exp_q[$];

  uart_freq_tx #(.DELAY_FRAMES(DF), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .send(send),
    .busy(busy), .done(done), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART receiver: samples mid-bit on the falling clock edge.
  always begin : rx_mon
    byte unsigned b;
    @(negedge clk);
    if (rst_n && uart_tx === 1'b0) begin
      b = 8'h00;
      repeat (DF/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DF) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (DF) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  function automatic string exp_frame(input logic [31:0] v);
    string s;
    longint unsigned x, lim;
    s = "";
    x = 64'(v);
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * 10;
    if (x >= lim) begin
      for (int i = 0; i < ND; i++) s = {s, "9"};
    end else begin
      for (int i = 0; i < ND; i++) begin
        s = $sformatf("%0d%s", x % 10, s);
        x = x / 10;
      end
`ifdef UART_TX_ZERO_SUPPRESS_EN
      while (s.len() > 1 && s.getc(0) == 8'h30) s = s.substr(1, s.len() - 1);
`endif
    end
    return {s, "\015\012"};
  endfunction

  function automatic string show(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == 8'h0D)      r = {r, "\\r"};
      else if (s.getc(i) == 8'h0A) r = {r, "\\n"};
      else                         r = {r, $sformatf("%c", s.getc(i))};
    end
    return r;
  endfunction

  // Push the expected frame and pulse send; t0 is the cycle count after the sampling edge.
  task automatic do_send(input logic [31:0] v, output int t0, output int nch);
    string s;
    s = exp_frame(v);
    nch = s.len();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
    @(negedge clk);
    value = v;
    send  = 1'b1;
    @(negedge clk);
    send  = 1'b0;
    value = $urandom;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pop_frame(output string got, output string exp);
    got = "";
    exp = "";
    while (rx_q.size() > 0)  got = {got, $sformatf("%c", rx_q.pop_front())};
    while (exp_q.size() > 0) exp = {exp, $sformatf("%c", exp_q.pop_front())};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0, nch, ts, td, bad;
    logic prev, busy_at_done;
    string got, exp, lit;
    do_send(32'd1000000, t0, nch);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_start(100, ts);
    n_checks++; if (ts != t0 + 33) begin n_fail++; $display("FAIL basic_start: got %0d expected %0d", ts, t0 + 33); end
    prev = 1'b0; bad = 0; td = -1; busy_at_done = 1'bx;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (uart_tx !== prev) begin
        if (((cyc - ts) % DF) != 0) bad++;
        prev = uart_tx;
      end
      if (done === 1'b1) begin
        td = cyc;
        busy_at_done = busy;
        break;
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_bitwidth: got %0d off-boundary edges expected 0", bad); end
    n_checks++; if (td != t0 + 33 + nch*10*DF) begin n_fail++; $display("FAIL basic_done_time: got %0d expected %0d", td, t0 + 33 + nch*10*DF); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    pop_frame(got, exp);
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL basic_frame: got \"%s\" expected \"%s\"", show(got), show(exp)); end
`ifdef UART_TX_ZERO_SUPPRESS_EN
    lit = "1000000\015\012";
`else
    lit = "01000000\015\012";
`endif
    n_checks++; if (got != lit) begin n_fail++; $display("FAIL basic_literal: got \"%s\" expected \"%s\"", show(got), show(lit)); end
  endtask

  task automatic test_values();
    logic [31:0] vals [5];
    int t0, nch, td;
    string got, exp;
    vals[0] = 32'd99999999;
    vals[1] = 32'd100000000;
    vals[2] = 32'd0;
    vals[3] = 32'hFFFF_FFFF;
    vals[4] = 32'd12345;
    for (int k = 0; k < 5; k++) begin
      do_send(vals[k], t0, nch);
      wait_done(2000, td);
      n_checks++; if (td != t0 + 33 + nch*10*DF) begin n_fail++; $display("FAIL values_done_time[%0d]: got %0d expected %0d", vals[k], td, t0 + 33 + nch*10*DF); end
      pop_frame(got, exp);
      n_checks++; if (got != exp) begin n_fail++; $display("FAIL values_frame[%0d]: got \"%s\" expected \"%s\"", vals[k], show(got), show(exp)); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, nch, td, t0b, ts, td2;
    string got, exp, s;
    do_send(32'd24681357, t0, nch);
    td = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      send = (cyc == t0 + 99 || cyc == t0 + 499);
      if (done === 1'b1) begin
        td = cyc;
        break;
      end
    end
    // Request on the done cycle: must be dropped.
    send = 1'b1;
    n_checks++; if (td != t0 + 33 + nch*10*DF) begin n_fail++; $display("FAIL b2b_done_time: got %0d expected %0d", td, t0 + 33 + nch*10*DF); end
    @(negedge clk);
    send = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle_send: busy got %b expected 0", busy); end
    pop_frame(got, exp);
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL b2b_single_frame: got \"%s\" expected \"%s\"", show(got), show(exp)); end
    // Request on the cycle after done: accepted.
    s = exp_frame(32'd505);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
    send  = 1'b1;
    value = 32'd505;
    @(negedge clk);
    send = 1'b0;
    t0b  = cyc;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    wait_start(100, ts);
    n_checks++; if (ts != t0b + 33) begin n_fail++; $display("FAIL b2b_second_start: got %0d expected %0d", ts, t0b + 33); end
    wait_done(2000, td2);
    pop_frame(got, exp);
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL b2b_second_frame: got \"%s\" expected \"%s\"", show(got), show(exp)); end
  endtask

  task automatic test_mid_reset();
    int t0, nch, td, bad;
    string got, exp, lit;
    do_send(32'd87654321, t0, nch);
    // Third character '6' (0x36): bit 0 is low, 10 cycles into the character.
    for (int i = 0; i < 400 && cyc < t0 + 33 + 2*10*DF + 10; i++) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_tx: got %b expected 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", uart_tx); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_idle: got %0d non-idle cycles expected 0", bad); end
    rx_q.delete();
    exp_q.delete();
    do_send(32'd12345678, t0, nch);
    wait_done(2000, td);
    pop_frame(got, exp);
    lit = "12345678\015\012";
    n_checks++; if (got != lit) begin n_fail++; $display("FAIL midrst_frame: got \"%s\" expected \"%s\"", show(got), show(lit)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
